// File: rtl/qam_mod_mixer_if.sv
// Symbol, carrier and modulated-output handshakes of the QAM mixer, plus the
// run-time mode select and level-error reporting.
interface qam_mod_mixer_if #(
    parameter int CW    = 8,
    parameter int LW    = 4,
    parameter int OUT_W = 10
);
    logic [1:0]              cfg_mode;
    logic                    sym_valid;
    logic                    sym_ready;
    logic signed [LW-1:0]    sym_i;
    logic signed [LW-1:0]    sym_q;
    logic                    cor_valid;
    logic                    cor_ready;
    logic signed [CW-1:0]    sin;
    logic signed [CW-1:0]    cos;
    logic                    qam_valid;
    logic                    qam_ready;
    logic signed [OUT_W-1:0] qam_out;
    logic                    qam_sat;
    logic                    err_level;
    logic [7:0]              err_cnt;
    logic                    err_clr;

    modport slave (
        input  cfg_mode, sym_valid, sym_i, sym_q, cor_valid, sin, cos,
               qam_ready, err_clr,
        output sym_ready, cor_ready, qam_valid, qam_out, qam_sat,
               err_level, err_cnt
    );

    modport master (
        output cfg_mode, sym_valid, sym_i, sym_q, cor_valid, sin, cos,
               qam_ready, err_clr,
        input  sym_ready, cor_ready, qam_valid, qam_out, qam_sat,
               err_level, err_cnt
    );
endinterface

// File: rtl/qam_mod_mixer.sv
// Three-stage QAM mixer: qam_out = I*cos - Q*sin with level checking,
// rounding/saturation and valid/ready flow control on all streams.
module qam_mod_mixer #(
    parameter int CW    = 8,
    parameter int LW    = 4,
    parameter int OUT_W = 10,
    parameter int SHIFT = 0
) (
    input  logic           axi_clk,
    input  logic           axi_rstn,
    qam_mod_mixer_if.slave bus
);
    localparam int PW  = CW + LW - 1;
    localparam int FW  = CW + LW;
    localparam int LW1 = LW + 1;
    localparam int EW  = (OUT_W >= FW + 1) ? OUT_W + 1 : FW + 1;
    localparam int RND = (1 << SHIFT) >> 1;
    localparam logic signed [EW-1:0] SAT_HI = EW'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
    localparam logic signed [EW-1:0] SAT_LO = ~SAT_HI;

    // Odd and within the constellation's magnitude limit; mode 3 rejects all.
    function automatic logic lvl_ok(input logic signed [LW-1:0] lvl,
                                    input logic [1:0] mode);
        logic signed [LW:0] w;
        logic signed [LW:0] mag;
        logic signed [LW:0] lim;
        w   = LW1'(lvl);
        mag = (w < 0) ? -w : w;
        case (mode)
            2'd0:    lim = LW1'(1);
            2'd1:    lim = LW1'(3);
            2'd2:    lim = LW1'(7);
            default: lim = '0;
        endcase
        return lvl[0] && (mag <= lim);
    endfunction

    function automatic logic [OUT_W:0] round_sat(input logic signed [FW-1:0] sum);
        logic signed [EW-1:0] x;
        x = (EW'(sum) + EW'(RND)) >>> SHIFT;
        if (x > SAT_HI)
            return {1'b1, SAT_HI[OUT_W-1:0]};
        else if (x < SAT_LO)
            return {1'b1, SAT_LO[OUT_W-1:0]};
        return {1'b0, x[OUT_W-1:0]};
    endfunction

    logic vld_p0, vld_p1, vld_p2;
    logic ld_p0, ld_p1, ld_p2, s1_free, fire;
    logic ok_i, ok_q, err_hit;

    logic signed [LW-1:0]    i_p0, nq_p0;
    logic signed [CW-1:0]    cos_p0, sin_p0;
    logic signed [PW-1:0]    p_i_p1, p_q_p1;
    logic signed [OUT_W-1:0] out_p2;
    logic                    sat_p2;
    logic [7:0]              err_cnt_r;
    logic                    err_level_r;

    assign ld_p2   = !vld_p2 || bus.qam_ready;
    assign ld_p1   = !vld_p1 || ld_p2;
    assign ld_p0   = !vld_p0 || ld_p1;
    // Ready is held off while reset is asserted, not just after it.
    assign s1_free = axi_rstn && ld_p0;
    assign fire    = bus.sym_valid && bus.cor_valid && s1_free;

    assign bus.sym_ready = s1_free && bus.cor_valid;
    assign bus.cor_ready = s1_free && bus.sym_valid;

    assign ok_i    = lvl_ok(bus.sym_i, bus.cfg_mode);
    assign ok_q    = lvl_ok(bus.sym_q, bus.cfg_mode);
    assign err_hit = fire && !(ok_i && ok_q);

    always_ff @(posedge axi_clk or negedge axi_rstn) begin
        if (!axi_rstn) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else begin
            if (ld_p0) vld_p0 <= fire;
            if (ld_p1) vld_p1 <= vld_p0;
            if (ld_p2) vld_p2 <= vld_p1;
        end
    end

    // S1: decoded levels (invalid channel forced to 0), Q pre-negated
    always_ff @(posedge axi_clk) begin
        if (fire) begin
            i_p0   <= ok_i ? bus.sym_i : '0;
            nq_p0  <= ok_q ? -bus.sym_q : '0;
            cos_p0 <= bus.cos;
            sin_p0 <= bus.sin;
        end
    end

    // S2: partial products
    always_ff @(posedge axi_clk) begin
        if (ld_p1 && vld_p0) begin
            p_i_p1 <= PW'(i_p0) * PW'(cos_p0);
            p_q_p1 <= PW'(nq_p0) * PW'(sin_p0);
        end
    end

    // S3: sum, round, saturate into the output register
    always_ff @(posedge axi_clk or negedge axi_rstn) begin
        if (!axi_rstn) begin
            out_p2 <= '0;
            sat_p2 <= 1'b0;
        end else if (ld_p2 && vld_p1) begin
            {sat_p2, out_p2} <= round_sat(FW'(p_i_p1) + FW'(p_q_p1));
        end
    end

    // A clear coinciding with an error leaves exactly that one error counted.
    always_ff @(posedge axi_clk or negedge axi_rstn) begin
        if (!axi_rstn) begin
            err_cnt_r   <= '0;
            err_level_r <= 1'b0;
        end else if (err_hit) begin
            err_cnt_r   <= bus.err_clr ? 8'd1 :
                           (err_cnt_r == 8'hFF) ? 8'hFF : err_cnt_r + 8'd1;
            err_level_r <= 1'b1;
        end else if (bus.err_clr) begin
            err_cnt_r   <= '0;
            err_level_r <= 1'b0;
        end
    end

    assign bus.qam_valid = vld_p2;
    assign bus.qam_out   = out_p2;
    assign bus.qam_sat   = sat_p2;
    assign bus.err_cnt   = err_cnt_r;
    assign bus.err_level = err_level_r;
endmodule

// File: tb/tb_qam_mod_mixer.sv
// Bench for qam_mod_mixer: two instances (plain and rounded/narrow output) share
// stimulus; a reference model predicts every output beat in order.
module tb_qam_mod_mixer;
    localparam int CW = 8;
    localparam int LW = 4;

    logic axi_clk = 1'b0;
    logic axi_rstn;
    always #5 axi_clk = ~axi_clk;

    logic [1:0]           cfg_mode;
    logic                 sym_valid, cor_valid, qam_ready, err_clr;
    logic signed [LW-1:0] sym_i, sym_q;
    logic signed [CW-1:0] sin_s, cos_s;

    qam_mod_mixer_if #(.CW(CW), .LW(LW), .OUT_W(10)) bus0 ();
    qam_mod_mixer_if #(.CW(CW), .LW(LW), .OUT_W(8))  bus1 ();

    assign bus0.cfg_mode = cfg_mode;   assign bus1.cfg_mode = cfg_mode;
    assign bus0.sym_valid = sym_valid; assign bus1.sym_valid = sym_valid;
    assign bus0.sym_i = sym_i;         assign bus1.sym_i = sym_i;
    assign bus0.sym_q = sym_q;         assign bus1.sym_q = sym_q;
    assign bus0.cor_valid = cor_valid; assign bus1.cor_valid = cor_valid;
    assign bus0.sin = sin_s;           assign bus1.sin = sin_s;
    assign bus0.cos = cos_s;           assign bus1.cos = cos_s;
    assign bus0.qam_ready = qam_ready; assign bus1.qam_ready = qam_ready;
    assign bus0.err_clr = err_clr;     assign bus1.err_clr = err_clr;

    qam_mod_mixer #(.CW(CW), .LW(LW), .OUT_W(10), .SHIFT(0)) dut0 (
        .axi_clk(axi_clk), .axi_rstn(axi_rstn), .bus(bus0));
    qam_mod_mixer #(.CW(CW), .LW(LW), .OUT_W(8), .SHIFT(2)) dut1 (
        .axi_clk(axi_clk), .axi_rstn(axi_rstn), .bus(bus1));

    int checks = 0;
    int errors = 0;

    typedef struct {
        int o0; bit s0;
        int o1; bit s1;
    } exp_t;
    exp_t exp_q[$];
    exp_t e_push, e_pop;

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic bit lvl_valid(input int l, input int m);
        int lim;
        lim = (m == 0) ? 1 : (m == 1) ? 3 : (m == 2) ? 7 : -1;
        return (l % 2 != 0) && (l <= lim) && (l >= -lim);
    endfunction

    function automatic int ref_out(input int i, input int q, input int c, input int s,
                                   input int m, input int sh, input int ow,
                                   output bit sat);
        int v, hi, lo;
        v = (lvl_valid(i, m) ? i : 0) * c - (lvl_valid(q, m) ? q : 0) * s;
        if (sh > 0) v = (v + (1 << (sh - 1))) >>> sh;
        hi = (1 << (ow - 1)) - 1;
        lo = -(1 << (ow - 1));
        sat = (v > hi) || (v < lo);
        if (v > hi) v = hi;
        if (v < lo) v = lo;
        return v;
    endfunction

    // Scoreboard: predict at each handshake, compare at each output beat.
    bit stall_prev = 0;
    logic signed [9:0] held_out;
    logic held_sat;
    always @(negedge axi_clk) begin
        if (!axi_rstn) begin
            stall_prev = 0;
        end else begin
            if (stall_prev) begin
                chk("hold_valid", bus0.qam_valid, 1);
                chk("hold_out", bus0.qam_out, held_out);
                chk("hold_sat", bus0.qam_sat, held_sat);
            end
            if (bus0.qam_valid && bus0.qam_ready) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_beat", exp_q.size(), 1);
                end else begin
                    e_pop = exp_q.pop_front();
                    chk("out0", bus0.qam_out, e_pop.o0);
                    chk("sat0", bus0.qam_sat, e_pop.s0);
                    chk("valid1", bus1.qam_valid, 1);
                    chk("out1", bus1.qam_out, e_pop.o1);
                    chk("sat1", bus1.qam_sat, e_pop.s1);
                end
            end
            if (sym_valid && cor_valid && bus0.sym_ready) begin
                e_push.o0 = ref_out(int'(sym_i), int'(sym_q), int'(cos_s), int'(sin_s),
                                    int'(cfg_mode), 0, 10, e_push.s0);
                e_push.o1 = ref_out(int'(sym_i), int'(sym_q), int'(cos_s), int'(sin_s),
                                    int'(cfg_mode), 2, 8, e_push.s1);
                exp_q.push_back(e_push);
            end
            stall_prev = bus0.qam_valid && !bus0.qam_ready;
            held_out   = bus0.qam_out;
            held_sat   = bus0.qam_sat;
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input int i, input int q, input int c, input int s, input int m);
        bit acc;
        sym_i = LW'(i); sym_q = LW'(q); cos_s = CW'(c); sin_s = CW'(s);
        cfg_mode = 2'(m);
        sym_valid = 1; cor_valid = 1;
        acc = 0;
        for (int k = 0; k < 64; k++) begin
            @(negedge axi_clk);
            if (bus0.sym_ready) begin acc = 1; break; end
        end
        chk("accept", acc, 1);
        @(posedge axi_clk); #1;
        sym_valid = 0; cor_valid = 0;
    endtask

    task automatic expect_beat(input string tag, input int o0, input bit s0, input int o1);
        int k;
        for (k = 1; k <= 8; k++) begin
            @(negedge axi_clk);
            if (bus0.qam_valid) break;
        end
        chk({tag, "_lat"}, k, 3);
        chk({tag, "_out"}, bus0.qam_out, o0);
        chk({tag, "_sat"}, bus0.qam_sat, s0);
        chk({tag, "_out1"}, bus1.qam_out, o1);
        @(posedge axi_clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int nacc, stall_acc, cyc;
        axi_rstn = 0;
        cfg_mode = 0; sym_i = 0; sym_q = 0; sin_s = 0; cos_s = 0;
        sym_valid = 1; cor_valid = 1; qam_ready = 1; err_clr = 0;
        repeat (2) @(negedge axi_clk);
        chk("rst_sym_ready", bus0.sym_ready, 0);
        chk("rst_cor_ready", bus0.cor_ready, 0);
        chk("rst_valid", bus0.qam_valid, 0);
        chk("rst_out", bus0.qam_out, 0);
        chk("rst_sat", bus0.qam_sat, 0);
        chk("rst_err_level", bus0.err_level, 0);
        chk("rst_err_cnt", bus0.err_cnt, 0);
        sym_valid = 0; cor_valid = 0;
        @(posedge axi_clk); #1;
        axi_rstn = 1;

        send(3, -1, 64, 32, 1);       expect_beat("basic", 224, 0, 56);
        // Both terms add here: (-3)(-128) - (3)(-128) = 768, which clips.
        send(-3, 3, -128, -128, 1);   expect_beat("basic_b", 511, 1, 127);
        send(7, -7, 127, 127, 2);     expect_beat("sat_hi", 511, 1, 127);
        send(-7, 7, 127, 127, 2);     expect_beat("sat_lo", -512, 1, -128);
        send(1, 1, 100, 40, 2);       expect_beat("nosat", 60, 0, 15);
        send(1, 1, 6, 0, 1);          expect_beat("round", 6, 0, 2);

        send(5, 1, 20, 10, 1);        expect_beat("inv_i", -10, 0, -2);
        chk("err_level_1", bus0.err_level, 1);
        chk("err_cnt_1", bus0.err_cnt, 1);
        send(2, 1, 20, 10, 1);        expect_beat("even_i", -10, 0, -2);
        chk("err_cnt_2", bus0.err_cnt, 2);
        send(3, -3, 50, 60, 3);       expect_beat("mode3", 0, 0, 0);
        chk("err_cnt_3", bus0.err_cnt, 3);
        err_clr = 1;
        send(2, 1, 20, 10, 1);
        err_clr = 0;
        expect_beat("clr_err", -10, 0, -2);
        chk("clr_with_err_cnt", bus0.err_cnt, 1);
        chk("clr_with_err_lvl", bus0.err_level, 1);
        for (int n = 0; n < 300; n++) send(1, 1, 5, 5, 3);
        chk("err_cnt_sat", bus0.err_cnt, 255);

        // Random stream with a 5-cycle output stall and a flickering carrier.
        nacc = 0; stall_acc = 0; cyc = 0;
        sym_i = LW'($urandom()); sym_q = LW'($urandom());
        cos_s = CW'($urandom()); sin_s = CW'($urandom()); cfg_mode = 2'($urandom());
        while (nacc < 40 && cyc < 400) begin
            sym_valid = 1;
            cor_valid = 1'($urandom_range(0, 1));
            qam_ready = !(cyc >= 6 && cyc < 11);
            @(negedge axi_clk);
            if (!cor_valid) chk("join_sym_ready", bus0.sym_ready, 0);
            if (cor_valid && bus0.sym_ready) begin
                nacc++;
                if (!qam_ready) stall_acc++;
            end
            @(posedge axi_clk); #1;
            if (cor_valid && sym_valid && nacc > 0) begin
                sym_i = ($urandom_range(0, 3) != 0) ? LW'(2 * $urandom_range(0, 7) - 7)
                                                    : LW'($urandom());
                sym_q = ($urandom_range(0, 3) != 0) ? LW'(2 * $urandom_range(0, 7) - 7)
                                                    : LW'($urandom());
                cos_s = CW'($urandom()); sin_s = CW'($urandom());
                cfg_mode = 2'($urandom());
            end
            cyc++;
        end
        sym_valid = 0; cor_valid = 0; qam_ready = 1;
        chk("stream_count", nacc, 40);
        chk("stall_accepts_le3", stall_acc <= 3, 1);
        repeat (6) @(posedge axi_clk);
        #1;
        chk("stream_drained", exp_q.size(), 0);

        // Async reset with three beats held in the pipeline.
        err_clr = 1; @(posedge axi_clk); #1; err_clr = 0;
        chk("clr_cnt", bus0.err_cnt, 0);
        chk("clr_lvl", bus0.err_level, 0);
        qam_ready = 0;
        send(1, 1, 10, 10, 1);
        send(3, 3, 10, 10, 1);
        send(5, 1, 10, 10, 1);
        chk("full_err_cnt", bus0.err_cnt, 1);
        sym_valid = 1; cor_valid = 1;
        #0;
        chk("full_sym_ready", bus0.sym_ready, 0);
        chk("full_valid", bus0.qam_valid, 1);
        #2;
        axi_rstn = 0;
        #1;
        chk("arst_valid", bus0.qam_valid, 0);
        chk("arst_err_cnt", bus0.err_cnt, 0);
        chk("arst_sym_ready", bus0.sym_ready, 0);
        chk("arst_cor_ready", bus0.cor_ready, 0);
        exp_q.delete();
        sym_valid = 0; cor_valid = 0; qam_ready = 1;
        repeat (2) @(posedge axi_clk);
        #1;
        axi_rstn = 1;
        repeat (4) begin
            @(negedge axi_clk);
            chk("no_stale", bus0.qam_valid, 0);
        end
        @(posedge axi_clk); #1;
        send(1, -3, 40, 30, 2);       expect_beat("fresh", 130, 0, 33);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
